// File: rtl/battle_turn_sequencer_pkg.sv
// Shared choice codes, FSM state encodings and small helpers for the battle turn sequencer,
// the battle engine and the display logic.
package battle_turn_sequencer_pkg;

   typedef enum logic [1:0] {
      CH_DEFEND = 2'b00,
      CH_FIST   = 2'b01,
      CH_SWORD  = 2'b10,
      CH_BAT    = 2'b11
   } choice_e;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_P   = 3'd1,
      ST_P_STRIKE = 3'd2,
      ST_P_SETTLE = 3'd3,
      ST_E_THINK  = 3'd4,
      ST_E_STRIKE = 3'd5,
      ST_E_SETTLE = 3'd6,
      ST_DONE     = 3'd7
   } state_e;

   localparam int unsigned CNT_W    = 8;
   localparam logic [7:0]  TURN_MAX = 8'hFF;

   // Fibonacci form of x^8+x^6+x^5+x^4+1: taps on bits 7,5,4,3, shift toward the MSB.
   function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   // A weapon choice is only usable while that weapon has uses left.
   function automatic logic choice_legal(input logic [1:0] ch,
                                         input logic [4:0] sword,
                                         input logic [4:0] bat);
      return !((ch == CH_SWORD && sword == 5'd0) || (ch == CH_BAT && bat == 5'd0));
   endfunction

   // The enemy never stalls: an exhausted weapon falls back to a fist attack.
   function automatic logic [1:0] enemy_remap(input logic [1:0] raw,
                                              input logic [4:0] sword,
                                              input logic [4:0] bat);
      if (raw == CH_SWORD && sword == 5'd0) return CH_FIST;
      if (raw == CH_BAT && bat == 5'd0)     return CH_FIST;
      return raw;
   endfunction

endpackage

// File: rtl/battle_turn_sequencer_lfsr.sv
// Free-running 8-bit maximal-length LFSR used as the enemy's source of randomness.
module rpg_lfsr8
   import battle_turn_sequencer_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] lfsr
);

   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr8_next(lfsr_q);
   end

   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= SEED;
      else     lfsr_q <= lfsr_d;
   end

   assign lfsr = lfsr_q;

endmodule

// File: rtl/battle_turn_sequencer.sv
// Turn sequencer: turns a collision into alternating player/enemy strikes on the battle
// engine, pacing each strike with settle and think delays until a winner is reported.
module battle_turn_sequencer
   import battle_turn_sequencer_pkg::*;
#(
   parameter int         THINK_CYCLES  = 4,
   parameter int         SETTLE_CYCLES = 2,
   parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       collision_detected,
   input  logic       btn_valid,
   input  logic [1:0] btn_choice,
   input  logic [4:0] player_remained_sword,
   input  logic [4:0] player_remained_baseballbat,
   input  logic [4:0] enemy_remained_sword,
   input  logic [4:0] enemy_remained_baseballbat,
   input  logic       player_win,
   input  logic       enemy_win,
   output logic [1:0] player_choice,
   output logic [1:0] enemy_choice,
   output logic       player_turn,
   output logic       attacker_turn,
   output logic       battle_active,
   output logic [7:0] turn_count
);

   localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] THINK_INIT  = CNT_W'(THINK_CYCLES);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       pch_q, pch_d;
   logic [1:0]       ech_q, ech_d;
   logic [7:0]       tc_q, tc_d;
   logic [7:0]       lfsr;
   logic             any_win;
   logic             in_battle;
   logic             unused_lfsr;

   rpg_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .lfsr (lfsr)
   );

   assign unused_lfsr = ^lfsr[7:2];
   assign any_win     = player_win | enemy_win;
   assign in_battle   = (state_q != ST_IDLE) && (state_q != ST_DONE);

   // Settle windows end at 1 so the engine gets exactly SETTLE_CYCLES after a strobe;
   // the think window runs down to 0 and makes the enemy decision on its last cycle.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pch_d         = pch_q;
      ech_d         = ech_q;
      tc_d          = tc_q;
      player_turn   = 1'b0;
      attacker_turn = 1'b0;

      if (in_battle && !collision_detected) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         pch_d   = CH_DEFEND;
         ech_d   = CH_DEFEND;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (collision_detected) begin
                  state_d = ST_WAIT_P;
                  tc_d    = '0;
                  pch_d   = CH_DEFEND;
                  ech_d   = CH_DEFEND;
               end
            end
            ST_WAIT_P: begin
               if (btn_valid && choice_legal(btn_choice, player_remained_sword,
                                             player_remained_baseballbat)) begin
                  pch_d   = btn_choice;
                  state_d = ST_P_STRIKE;
               end
            end
            ST_P_STRIKE: begin
               player_turn = 1'b1;
               state_d     = ST_P_SETTLE;
               cnt_d       = SETTLE_INIT;
            end
            ST_P_SETTLE: begin
               if (cnt_q <= CNT_W'(1)) begin
                  if (any_win) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_E_THINK;
                     cnt_d   = THINK_INIT;
                  end
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            ST_E_THINK: begin
               if (cnt_q == '0) begin
                  ech_d   = enemy_remap(lfsr[1:0], enemy_remained_sword,
                                        enemy_remained_baseballbat);
                  state_d = ST_E_STRIKE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            ST_E_STRIKE: begin
               attacker_turn = 1'b1;
               state_d       = ST_E_SETTLE;
               cnt_d         = SETTLE_INIT;
            end
            ST_E_SETTLE: begin
               if (cnt_q <= CNT_W'(1)) begin
                  if (any_win) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_WAIT_P;
                     if (tc_q != TURN_MAX) tc_d = tc_q + 8'd1;
                  end
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            ST_DONE: begin
               if (!collision_detected) state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pch_q   <= CH_DEFEND;
         ech_q   <= CH_DEFEND;
         tc_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pch_q   <= pch_d;
         ech_q   <= ech_d;
         tc_q    <= tc_d;
      end
   end

   assign player_choice = pch_q;
   assign enemy_choice  = ech_q;
   assign battle_active = (state_q != ST_IDLE);
   assign turn_count    = tc_q;

endmodule

// File: tb/tb_battle_turn_sequencer.sv
// Directed bench: stimulus pushes expected strobes into a queue, a negedge monitor pops
// and checks them; enemy choices are predicted from an independent LFSR model.
module tb_battle_turn_sequencer;

   localparam int S  = 2;
   localparam int TH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       collision_detected = 1'b0;
   logic       btn_valid = 1'b0;
   logic [1:0] btn_choice = 2'b00;
   logic [4:0] p_sword = 5'd5, p_bat = 5'd5, e_sword = 5'd5, e_bat = 5'd5;
   logic       player_win = 1'b0, enemy_win = 1'b0;
   logic [1:0] player_choice, enemy_choice;
   logic       player_turn, attacker_turn, battle_active;
   logic [7:0] turn_count;

   battle_turn_sequencer #(
      .THINK_CYCLES  (TH),
      .SETTLE_CYCLES (S),
      .LFSR_SEED     (8'hA5)
   ) dut (
      .clk                         (clk),
      .rst                         (rst),
      .collision_detected          (collision_detected),
      .btn_valid                   (btn_valid),
      .btn_choice                  (btn_choice),
      .player_remained_sword       (p_sword),
      .player_remained_baseballbat (p_bat),
      .enemy_remained_sword        (e_sword),
      .enemy_remained_baseballbat  (e_bat),
      .player_win                  (player_win),
      .enemy_win                   (enemy_win),
      .player_choice               (player_choice),
      .enemy_choice                (enemy_choice),
      .player_turn                 (player_turn),
      .attacker_turn               (attacker_turn),
      .battle_active               (battle_active),
      .turn_count                  (turn_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         is_atk;
      int         cyc;
      logic [1:0] pch;
      logic [1:0] ech;
      int         tc;
   } exp_t;

   exp_t       q[$];
   exp_t       mon_e;
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         exp_tc = 0;
   logic [1:0] last_ec = 2'b00;
   logic [7:0] mdl;

   // x^8+x^6+x^5+x^4+1 -> feedback is parity of bits 7,5,4,3 (mask B8)
   function automatic logic [7:0] ref_step(input logic [7:0] s);
      return {s[6:0], ^(s & 8'hB8)};
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) mdl <= 8'hA5;
      else     mdl <= ref_step(mdl);
   end

   task automatic chk(input string nm, input int act, input int exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && (player_turn || attacker_turn)) begin
         chk("strobe_exclusive", int'(player_turn & attacker_turn), 0);
         if (q.size() == 0) begin
            chk("unexpected_strobe", 1, 0);
         end else begin
            mon_e = q.pop_front();
            chk("strobe_kind", int'(attacker_turn), int'(mon_e.is_atk));
            chk("strobe_cycle", cyc, mon_e.cyc);
            chk("strobe_player_choice", int'(player_choice), int'(mon_e.pch));
            if (mon_e.is_atk) chk("strobe_enemy_choice", int'(enemy_choice), int'(mon_e.ech));
            chk("strobe_turn_count", int'(turn_count), mon_e.tc);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_p(input logic [1:0] ch);
      exp_t e;
      e.is_atk = 1'b0; e.cyc = cyc + 1; e.pch = ch; e.ech = 2'b00; e.tc = exp_tc;
      q.push_back(e);
   endtask

   // Full round issued while in WAIT_P; returns in the next WAIT_P cycle.
   task automatic round(input logic [1:0] ch);
      exp_t       e;
      logic [7:0] l;
      logic [1:0] ec;
      l = mdl;
      repeat (S + TH + 2) l = ref_step(l);
      ec = l[1:0];
      if (ec == 2'b10 && e_sword == 5'd0) ec = 2'b01;
      if (ec == 2'b11 && e_bat == 5'd0)   ec = 2'b01;
      push_p(ch);
      e.is_atk = 1'b1; e.cyc = cyc + S + TH + 3; e.pch = ch; e.ech = ec; e.tc = exp_tc;
      q.push_back(e);
      last_ec = ec;
      btn_valid = 1'b1; btn_choice = ch;
      step(1);
      btn_valid = 1'b0;
      step(2 * S + TH + 3);
      if (exp_tc < 255) exp_tc++;
   endtask

   initial begin
      step(3);
      rst = 1'b0;
      step(1);
      chk("reset_battle_active", int'(battle_active), 0);
      chk("reset_turn_count", int'(turn_count), 0);
      chk("reset_player_choice", int'(player_choice), 0);
      chk("reset_enemy_choice", int'(enemy_choice), 0);
      chk("reset_strobes", int'({player_turn, attacker_turn}), 0);

      // 1: basic round
      collision_detected = 1'b1;
      step(1);
      chk("t1_active", int'(battle_active), 1);
      round(2'b01);
      chk("t1_turn_count", int'(turn_count), 1);
      chk("t1_player_choice", int'(player_choice), 1);
      chk("t1_enemy_choice", int'(enemy_choice), int'(last_ec));

      // 2: illegal sword ignored, bat accepted
      p_sword = 5'd0;
      btn_valid = 1'b1; btn_choice = 2'b10;
      step(1);
      btn_valid = 1'b0;
      step(12);
      chk("t2_still_waiting", int'(turn_count), 1);
      chk("t2_choice_kept", int'(player_choice), 1);
      p_bat = 5'd3;
      round(2'b11);
      chk("t2_turn_count", int'(turn_count), 2);

      // 3: enemy out of weapons -> always fist/defend
      e_sword = 5'd0; e_bat = 5'd0;
      for (int i = 0; i < 20; i++) round(i[0] ? 2'b01 : 2'b00);
      chk("t3_turn_count", int'(turn_count), exp_tc);
      e_sword = 5'd5; e_bat = 5'd5; p_sword = 5'd5;

      // 4: win during player settle -> DONE, no enemy strike
      push_p(2'b10);
      btn_valid = 1'b1; btn_choice = 2'b10;
      step(1);
      btn_valid = 1'b0;
      step(1);
      enemy_win = 1'b1;
      step(12);
      chk("t4_done_active", int'(battle_active), 1);
      chk("t4_done_choice", int'(player_choice), 2);
      chk("t4_done_count", int'(turn_count), exp_tc);
      enemy_win = 1'b0; collision_detected = 1'b0;
      step(1);
      chk("t4_idle", int'(battle_active), 0);

      // 5: abort during enemy think
      collision_detected = 1'b1;
      step(1);
      exp_tc = 0;
      chk("t5_count_cleared", int'(turn_count), 0);
      round(2'b01);
      chk("t5_round_enemy", int'(enemy_choice), int'(last_ec));
      push_p(2'b11);
      btn_valid = 1'b1; btn_choice = 2'b11;
      step(1);
      btn_valid = 1'b0;
      step(4);
      collision_detected = 1'b0;
      step(1);
      chk("t5_abort_idle", int'(battle_active), 0);
      chk("t5_abort_pch", int'(player_choice), 0);
      chk("t5_abort_ech", int'(enemy_choice), 0);
      step(12);

      // 6: turn counter saturation
      collision_detected = 1'b1;
      step(1);
      exp_tc = 0;
      for (int i = 0; i < 258; i++) round(2'b01);
      chk("t6_saturated", int'(turn_count), 255);
      collision_detected = 1'b0;
      step(3);
      chk("t6_idle", int'(battle_active), 0);

      chk("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
